// File: rtl/conv_tile_scheduler_if.sv
// Tile command channel between the conv tile scheduler and the array.
// Scheduler drives the command (master), the array answers (slave).
interface conv_tile_scheduler_if #(
  parameter int M_TOTAL = 3136,
  parameter int N_TOTAL = 64,
  parameter int K_TOTAL = 147,
  parameter int TILE_M  = 16,
  parameter int TILE_N  = 16,
  parameter int TILE_K  = 16
);
  localparam int MW  = $clog2(M_TOTAL + 1);
  localparam int NW  = $clog2(N_TOTAL + 1);
  localparam int KW  = $clog2(K_TOTAL + 1);
  localparam int MLW = $clog2(TILE_M + 1);
  localparam int NLW = $clog2(TILE_N + 1);
  localparam int KLW = $clog2(TILE_K + 1);

  logic           tile_valid;
  logic           tile_ready;
  logic [MW-1:0]  tile_m0;
  logic [NW-1:0]  tile_n0;
  logic [KW-1:0]  tile_k0;
  logic [MLW-1:0] tile_m_len;
  logic [NLW-1:0] tile_n_len;
  logic [KLW-1:0] tile_k_len;
  logic           acc_clear;
  logic           acc_flush;
  logic           tile_done;

  modport master (
    output tile_valid,
    output tile_m0, tile_n0, tile_k0,
    output tile_m_len, tile_n_len, tile_k_len,
    output acc_clear, acc_flush,
    input  tile_ready, tile_done
  );

  modport slave (
    input  tile_valid,
    input  tile_m0, tile_n0, tile_k0,
    input  tile_m_len, tile_n_len, tile_k_len,
    input  acc_clear, acc_flush,
    output tile_ready, tile_done
  );
endinterface

// File: rtl/conv_tile_scheduler.sv
// Conv layer as GEMM: walks (n,m,k) tiles and issues them to the array.
// Optional SCHED_PERF_CNT_EN adds perf_cycles / perf_tiles counters.
module conv_tile_scheduler #(
  parameter int M_TOTAL = 3136,
  parameter int N_TOTAL = 64,
  parameter int K_TOTAL = 147,
  parameter int TILE_M  = 16,
  parameter int TILE_N  = 16,
  parameter int TILE_K  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done,
  output logic busy,
`ifdef SCHED_PERF_CNT_EN
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_tiles,
`endif
  conv_tile_scheduler_if.master tile_if
);
  localparam int MW  = $clog2(M_TOTAL + 1);
  localparam int NW  = $clog2(N_TOTAL + 1);
  localparam int KW  = $clog2(K_TOTAL + 1);
  localparam int MLW = $clog2(TILE_M + 1);
  localparam int NLW = $clog2(TILE_N + 1);
  localparam int KLW = $clog2(TILE_K + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, ADVANCE, FIN
  } state_t;

  state_t state_q, state_d;

  logic [MW-1:0]  m0_q, m0_d;
  logic [NW-1:0]  n0_q, n0_d;
  logic [KW-1:0]  k0_q, k0_d;
  logic [MLW-1:0] ml_q, ml_d;
  logic [NLW-1:0] nl_q, nl_d;
  logic [KLW-1:0] kl_q, kl_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           load;
  logic           valid;
  logic           fire;

  logic [31:0] m_nx, n_nx, k_nx;
  logic        m_wrap, n_wrap, k_wrap;

  function automatic logic [31:0] seg_len(
    input logic [31:0] base,
    input logic [31:0] total,
    input logic [31:0] tile
  );
    logic [31:0] rem;
    rem = total - base;
    return (rem < tile) ? rem : tile;
  endfunction

  assign m_nx   = 32'(m0_q) + 32'(TILE_M);
  assign n_nx   = 32'(n0_q) + 32'(TILE_N);
  assign k_nx   = 32'(k0_q) + 32'(TILE_K);
  assign m_wrap = m_nx >= 32'(M_TOTAL);
  assign n_wrap = n_nx >= 32'(N_TOTAL);
  assign k_wrap = k_nx >= 32'(K_TOTAL);

  assign ml_d = MLW'(seg_len(32'(m0_d), 32'(M_TOTAL), 32'(TILE_M)));
  assign nl_d = NLW'(seg_len(32'(n0_d), 32'(N_TOTAL), 32'(TILE_N)));
  assign kl_d = KLW'(seg_len(32'(k0_d), 32'(K_TOTAL), 32'(TILE_K)));

  // next-state, index stepping (k inner, m middle, n outer)
  always_comb begin
    state_d = state_q;
    m0_d    = m0_q;
    n0_d    = n0_q;
    k0_d    = k0_q;
    done_d  = done_q;
    busy_d  = busy_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m0_d    = '0;
          n0_d    = '0;
          k0_d    = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (tile_if.tile_ready) state_d = WAIT;
      end
      WAIT: begin
        if (tile_if.tile_done) state_d = ADVANCE;
      end
      ADVANCE: begin
        if (k_wrap && m_wrap && n_wrap) begin
          state_d = FIN;
        end else begin
          state_d = ISSUE;
          load    = 1'b1;
          if (!k_wrap) begin
            k0_d = k_nx[KW-1:0];
          end else begin
            k0_d = '0;
            if (!m_wrap) begin
              m0_d = m_nx[MW-1:0];
            end else begin
              m0_d = '0;
              n0_d = n_nx[NW-1:0];
            end
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, indices and extents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m0_q    <= '0;
      n0_q    <= '0;
      k0_q    <= '0;
      ml_q    <= '0;
      nl_q    <= '0;
      kl_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m0_q    <= m0_d;
      n0_q    <= n0_d;
      k0_q    <= k0_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      if (load) begin
        ml_q <= ml_d;
        nl_q <= nl_d;
        kl_q <= kl_d;
      end
    end
  end

  assign valid = (state_q == ISSUE);
  assign fire  = valid && tile_if.tile_ready;

  assign tile_if.tile_valid = valid;
  assign tile_if.tile_m0    = m0_q;
  assign tile_if.tile_n0    = n0_q;
  assign tile_if.tile_k0    = k0_q;
  assign tile_if.tile_m_len = ml_q;
  assign tile_if.tile_n_len = nl_q;
  assign tile_if.tile_k_len = kl_q;
  assign tile_if.acc_clear  = valid && (k0_q == '0);
  assign tile_if.acc_flush  = valid &&
    ((32'(k0_q) + 32'(kl_q)) == 32'(K_TOTAL));

  assign done = done_q;
  assign busy = busy_q;

`ifdef SCHED_PERF_CNT_EN
  // busy-cycle and accepted-tile counters, cleared on accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_tiles  <= '0;
    end else if (state_q == IDLE && start) begin
      perf_cycles <= '0;
      perf_tiles  <= '0;
    end else begin
      if (busy_q) perf_cycles <= perf_cycles + 32'd1;
      if (fire)   perf_tiles  <= perf_tiles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench for conv_tile_scheduler: tables, corner sequences, random runs.
// Tile expectations come from a closed-form tile-index model.
module tb_conv_tile_scheduler;
  localparam int AM = 3136, AN = 64, AK = 147, AT = 16;
  localparam int BM = 20, BN = 16, BK = 20;
  localparam int CM = 37, CN = 21, CK = 33;
  localparam int CTM = 8, CTN = 4, CTK = 16;

  typedef struct packed {
    int   m0;
    int   n0;
    int   k0;
    int   ml;
    int   nl;
    int   kl;
    logic clr;
    logic fl;
  } tile_t;

  typedef struct packed {
    int    stall;
    tile_t exp;
  } row_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b, start_c;
  logic done_a, done_b, done_c;
  logic busy_a, busy_b, busy_c;

  always #5 clk = ~clk;

  conv_tile_scheduler_if #(
    .M_TOTAL(AM), .N_TOTAL(AN), .K_TOTAL(AK),
    .TILE_M(AT), .TILE_N(AT), .TILE_K(AT)
  ) if_a ();
  conv_tile_scheduler_if #(
    .M_TOTAL(BM), .N_TOTAL(BN), .K_TOTAL(BK),
    .TILE_M(16), .TILE_N(16), .TILE_K(16)
  ) if_b ();
  conv_tile_scheduler_if #(
    .M_TOTAL(CM), .N_TOTAL(CN), .K_TOTAL(CK),
    .TILE_M(CTM), .TILE_N(CTN), .TILE_K(CTK)
  ) if_c ();

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] pc_a, pt_a, pc_b, pt_b, pc_c, pt_c;
`endif

  conv_tile_scheduler #(
    .M_TOTAL(AM), .N_TOTAL(AN), .K_TOTAL(AK),
    .TILE_M(AT), .TILE_N(AT), .TILE_K(AT)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .done(done_a), .busy(busy_a),
`ifdef SCHED_PERF_CNT_EN
    .perf_cycles(pc_a), .perf_tiles(pt_a),
`endif
    .tile_if(if_a)
  );

  conv_tile_scheduler #(
    .M_TOTAL(BM), .N_TOTAL(BN), .K_TOTAL(BK),
    .TILE_M(16), .TILE_N(16), .TILE_K(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .done(done_b), .busy(busy_b),
`ifdef SCHED_PERF_CNT_EN
    .perf_cycles(pc_b), .perf_tiles(pt_b),
`endif
    .tile_if(if_b)
  );

  conv_tile_scheduler #(
    .M_TOTAL(CM), .N_TOTAL(CN), .K_TOTAL(CK),
    .TILE_M(CTM), .TILE_N(CTN), .TILE_K(CTK)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c),
    .done(done_c), .busy(busy_c),
`ifdef SCHED_PERF_CNT_EN
    .perf_cycles(pc_c), .perf_tiles(pt_c),
`endif
    .tile_if(if_c)
  );

  int n_chk = 0;
  int n_fail = 0;

  bit auto_a, auto_b, auto_c, rnd_c;
  int lat_a, lat_b, lat_c;
  int cnt_a, cnt_b, cnt_c;
  int idx_a, idx_b, idx_c;
  int busy_cnt_b;
  tile_t first_a, last_a;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // i-th tile of a layer, loops n outer, m middle, k inner
  function automatic tile_t exp_tile(int i, int m, int n, int k,
                                     int tm, int tn, int tk);
    tile_t e;
    int nk, nm;
    nk   = (k + tk - 1) / tk;
    nm   = (m + tm - 1) / tm;
    e.k0 = (i % nk) * tk;
    e.m0 = ((i / nk) % nm) * tm;
    e.n0 = (i / (nk * nm)) * tn;
    e.ml = imin(tm, m - e.m0);
    e.nl = imin(tn, n - e.n0);
    e.kl = imin(tk, k - e.k0);
    e.clr = (e.k0 == 0);
    e.fl  = (e.k0 + e.kl == k);
    return e;
  endfunction

  function automatic tile_t obs_a();
    tile_t o;
    o.m0 = int'(if_a.tile_m0);    o.n0 = int'(if_a.tile_n0);
    o.k0 = int'(if_a.tile_k0);    o.ml = int'(if_a.tile_m_len);
    o.nl = int'(if_a.tile_n_len); o.kl = int'(if_a.tile_k_len);
    o.clr = if_a.acc_clear;       o.fl = if_a.acc_flush;
    return o;
  endfunction

  function automatic tile_t obs_b();
    tile_t o;
    o.m0 = int'(if_b.tile_m0);    o.n0 = int'(if_b.tile_n0);
    o.k0 = int'(if_b.tile_k0);    o.ml = int'(if_b.tile_m_len);
    o.nl = int'(if_b.tile_n_len); o.kl = int'(if_b.tile_k_len);
    o.clr = if_b.acc_clear;       o.fl = if_b.acc_flush;
    return o;
  endfunction

  function automatic tile_t obs_c();
    tile_t o;
    o.m0 = int'(if_c.tile_m0);    o.n0 = int'(if_c.tile_n0);
    o.k0 = int'(if_c.tile_k0);    o.ml = int'(if_c.tile_m_len);
    o.nl = int'(if_c.tile_n_len); o.kl = int'(if_c.tile_k_len);
    o.clr = if_c.acc_clear;       o.fl = if_c.acc_flush;
    return o;
  endfunction

  task automatic chk(input string name, input longint got,
                     input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_tile(input string name, input tile_t got,
                          input tile_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got m0=%0d n0=%0d k0=%0d ml=%0d nl=%0d kl=%0d clr=%0b fl=%0b expected m0=%0d n0=%0d k0=%0d ml=%0d nl=%0d kl=%0d clr=%0b fl=%0b",
        name, got.m0, got.n0, got.k0, got.ml, got.nl, got.kl,
        got.clr, got.fl, exp.m0, exp.n0, exp.k0, exp.ml, exp.nl,
        exp.kl, exp.clr, exp.fl);
    end
  endtask

  // check every tile that will be accepted at the coming posedge
  task automatic mon();
    tile_t o;
    if (if_a.tile_valid && if_a.tile_ready) begin
      o = obs_a();
      chk_tile($sformatf("a_tile%0d", idx_a), o,
               exp_tile(idx_a, AM, AN, AK, AT, AT, AT));
      if (idx_a == 0) first_a = o;
      last_a = o;
      idx_a++;
      if (auto_a) cnt_a = lat_a;
    end
    if (if_b.tile_valid && if_b.tile_ready) begin
      chk_tile($sformatf("b_tile%0d", idx_b), obs_b(),
               exp_tile(idx_b, BM, BN, BK, 16, 16, 16));
      idx_b++;
      if (auto_b) cnt_b = lat_b;
    end
    if (if_c.tile_valid && if_c.tile_ready) begin
      chk_tile($sformatf("c_tile%0d", idx_c), obs_c(),
               exp_tile(idx_c, CM, CN, CK, CTM, CTN, CTK));
      idx_c++;
      if (auto_c) cnt_c = lat_c;
    end
  endtask

  // array-side responders, run at each negedge
  task automatic resp();
    if (busy_b) busy_cnt_b++;
    if (auto_a) begin
      if_a.tile_done = 1'b0;
      if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) if_a.tile_done = 1'b1;
      end
    end
    if (auto_b) begin
      if_b.tile_done = 1'b0;
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) if_b.tile_done = 1'b1;
      end
    end
    if (auto_c) begin
      if_c.tile_done = 1'b0;
      if (cnt_c > 0) begin
        cnt_c--;
        if (cnt_c == 0) if_c.tile_done = 1'b1;
      end
      if (rnd_c) begin
        if_c.tile_ready = ($urandom_range(0, 3) != 0);
        lat_c = $urandom_range(1, 5);
      end
    end
  endtask

  task automatic cyc();
    mon();
    @(negedge clk);
    resp();
  endtask

  task automatic wait_valid_a(input int bound);
    int t = 0;
    while (!if_a.tile_valid && t < bound) begin cyc(); t++; end
    chk("a_valid_wait", if_a.tile_valid, 1);
  endtask

  task automatic wait_valid_b(input int bound);
    int t = 0;
    while (!if_b.tile_valid && t < bound) begin cyc(); t++; end
    chk("b_valid_wait", if_b.tile_valid, 1);
  endtask

  task automatic wait_done_a(input int bound);
    int t = 0;
    while (!done_a && t < bound) begin cyc(); t++; end
    chk("a_done_wait", done_a, 1);
  endtask

  task automatic wait_done_b(input int bound);
    int t = 0;
    while (!done_b && t < bound) begin cyc(); t++; end
    chk("b_done_wait", done_b, 1);
  endtask

  task automatic wait_done_c(input int bound);
    int t = 0;
    while (!done_c && t < bound) begin cyc(); t++; end
    chk("c_done_wait", done_c, 1);
  endtask

  row_t  tbl [4];
  tile_t snap;
  int    t;
  int    vseen;

  initial begin
    tbl[0] = '{stall: 0, exp: '{m0: 0,  n0: 0, k0: 0,  ml: 16, nl: 16,
                                kl: 16, clr: 1'b1, fl: 1'b0}};
    tbl[1] = '{stall: 2, exp: '{m0: 0,  n0: 0, k0: 16, ml: 16, nl: 16,
                                kl: 4,  clr: 1'b0, fl: 1'b1}};
    tbl[2] = '{stall: 0, exp: '{m0: 16, n0: 0, k0: 0,  ml: 4,  nl: 16,
                                kl: 16, clr: 1'b1, fl: 1'b0}};
    tbl[3] = '{stall: 1, exp: '{m0: 16, n0: 0, k0: 16, ml: 4,  nl: 16,
                                kl: 4,  clr: 1'b0, fl: 1'b1}};

    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    if_a.tile_ready = 1'b0; if_a.tile_done = 1'b0;
    if_b.tile_ready = 1'b0; if_b.tile_done = 1'b0;
    if_c.tile_ready = 1'b0; if_c.tile_done = 1'b0;
    auto_a = 0; auto_b = 0; auto_c = 0; rnd_c = 0;
    lat_a = 3; lat_b = 2; lat_c = 1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    idx_a = 0; idx_b = 0; idx_c = 0;
    busy_cnt_b = 0;
    first_a = '0; last_a = '0;

    repeat (3) cyc();
    chk("rst_valid", if_a.tile_valid, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk_tile("rst_fields", obs_a(), '0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // spurious tile_done in IDLE
    if_a.tile_done = 1'b1; cyc(); if_a.tile_done = 1'b0; cyc();
    chk("idle_spur_valid", if_a.tile_valid, 0);
    chk("idle_spur_busy", busy_a, 0);
    chk("idle_spur_done", done_a, 0);

    // spurious tile_done in ISSUE and start while busy
    idx_a = 0; start_a = 1'b1; cyc(); start_a = 1'b0;
    chk("a_busy_after_start", busy_a, 1);
    wait_valid_a(10);
    snap = obs_a();
    chk_tile("a_first_issue", snap, exp_tile(0, AM, AN, AK, AT, AT, AT));
    if_a.tile_done = 1'b1; cyc(); if_a.tile_done = 1'b0;
    start_a = 1'b1; cyc(); start_a = 1'b0; cyc();
    chk("issue_spur_valid", if_a.tile_valid, 1);
    chk_tile("issue_spur_fields", obs_a(), snap);
    chk("issue_spur_idx", idx_a, 0);
    chk("issue_spur_busy", busy_a, 1);

    // reset while waiting on tile 50
    auto_a = 1; lat_a = 3; if_a.tile_ready = 1'b1;
    t = 0;
    while (idx_a < 51 && t < 1000) begin cyc(); t++; end
    chk("a_reach_tile50", idx_a, 51);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", if_a.tile_valid, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk_tile("midrst_fields", obs_a(), '0);
    auto_a = 0; cnt_a = 0; if_a.tile_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vseen = 0;
    repeat (5) begin
      cyc();
      if (if_a.tile_valid) vseen++;
    end
    chk("no_valid_after_rst", vseen, 0);

    // full default layer, tile_done 3 cycles after acceptance
    auto_a = 1; lat_a = 3; if_a.tile_ready = 1'b1;
    idx_a = 0; start_a = 1'b1; cyc(); start_a = 1'b0;
    wait_done_a(50000);
    chk("a_tile_count", idx_a, 4 * 196 * 10);
    chk("a_replay_clr", first_a.clr, 1);
    chk("a_replay_k0", first_a.k0, 0);
    chk("a_last_k0", last_a.k0, 144);
    chk("a_last_kl", last_a.kl, 3);
    chk("a_last_fl", last_a.fl, 1);
    chk("a_busy_end", busy_a, 0);
    auto_a = 0; if_a.tile_ready = 1'b0; if_a.tile_done = 1'b0;
    repeat (3) cyc();
    chk("a_done_sticky", done_a, 1);
    chk("a_idle_valid", if_a.tile_valid, 0);

    // small layer table, tile_done 2 cycles after acceptance
    busy_cnt_b = 0; idx_b = 0;
    start_b = 1'b1; cyc(); start_b = 1'b0;
    chk("b_busy_after_start", busy_b, 1);
    chk("b_done_after_start", done_b, 0);
    for (int r = 0; r < 4; r++) begin
      wait_valid_b(20);
      chk_tile($sformatf("tbl_row%0d", r), obs_b(), tbl[r].exp);
      repeat (tbl[r].stall) cyc();
      if_b.tile_ready = 1'b1; cyc(); if_b.tile_ready = 1'b0;
      cyc();
      if_b.tile_done = 1'b1; cyc(); if_b.tile_done = 1'b0;
    end
    wait_done_b(20);
    chk("b_busy_end", busy_b, 0);
    chk("b_tile_count", idx_b, 4);
`ifdef SCHED_PERF_CNT_EN
    chk("b_perf_tiles", longint'(pt_b), 4);
    chk("b_perf_cycles", longint'(pc_b), busy_cnt_b);
    repeat (3) cyc();
    chk("b_perf_frozen", longint'(pc_b), busy_cnt_b);
`endif
    repeat (3) cyc();
    chk("b_done_sticky", done_b, 1);

    // held-off ready keeps the command stable
    idx_b = 0;
    start_b = 1'b1; cyc(); start_b = 1'b0;
    chk("b_done_cleared", done_b, 0);
    wait_valid_b(20);
    snap = obs_b();
    for (int s = 0; s < 5; s++) begin
      cyc();
      chk($sformatf("stall_valid%0d", s), if_b.tile_valid, 1);
      chk_tile($sformatf("stall_fields%0d", s), obs_b(), snap);
    end
    chk("stall_idx", idx_b, 0);
    auto_b = 1; lat_b = 2; if_b.tile_ready = 1'b1;
    wait_done_b(200);
    chk("b_stall_count", idx_b, 4);
    auto_b = 0; if_b.tile_ready = 1'b0; if_b.tile_done = 1'b0;

    // randomized ready and latency on odd-sized layer
    for (int run = 0; run < 3; run++) begin
      auto_c = 1; rnd_c = 1; cnt_c = 0; idx_c = 0;
      start_c = 1'b1; cyc(); start_c = 1'b0;
      wait_done_c(4000);
      chk($sformatf("c_tile_count%0d", run), idx_c, 5 * 6 * 3);
      chk($sformatf("c_busy_end%0d", run), busy_c, 0);
      cyc();
    end
    auto_c = 0; rnd_c = 0;
    if_c.tile_ready = 1'b0; if_c.tile_done = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_tile_scheduler.md
CONV_TILE_SCHEDULER -- requirements
Module: conv_tile_scheduler

Interface
REQ-001 SHALL have parameter M_TOTAL, default 3136, output pixels (H_OUT*W_OUT) = GEMM rows.
REQ-002 SHALL have parameter N_TOTAL, default 64, output channels = GEMM columns.
REQ-003 SHALL have parameter K_TOTAL, default 147, reduction length (CIN*KH*KW).
REQ-004 SHALL have parameters TILE_M, TILE_N, TILE_K, default 16 each, array tile dimensions.
REQ-005 SHALL have ports clk (input, 1, clock) and rst_n (input, 1, reset); one clock, reset asynchronous and active-low.
REQ-006 SHALL have port start (input, 1): begin a full-layer schedule.
REQ-007 SHALL have port done (output, 1): sticky layer-complete flag.
REQ-008 SHALL have port busy (output, 1): high from accepted start until done rises.
REQ-009 SHALL have ports tile_valid (output, 1) and tile_ready (input, 1): tile command handshake.
REQ-010 SHALL have ports tile_m0, tile_n0, tile_k0 (output, $clog2 of the matching TOTAL+1): tile base indices.
REQ-011 SHALL have ports tile_m_len, tile_n_len, tile_k_len (output, $clog2 of the matching TILE+1): valid extents.
REQ-012 SHALL have ports acc_clear and acc_flush (output, 1 each): first-k and last-k tile markers.
REQ-013 SHALL have port tile_done (input, 1): single-cycle completion pulse from the array.

Function
REQ-014 SHALL order loops n outer, m middle, k inner, each stepping by its TILE size from 0.
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, ADVANCE, FIN.
REQ-016 IDLE: start=1 SHALL clear done, zero all indices, set busy, go to ISSUE next cycle.
REQ-017 ISSUE: tile_valid=1 with stable command fields; on tile_valid&tile_ready SHALL go to WAIT.
REQ-018 WAIT: tile_valid=0; on tile_done SHALL go to ADVANCE; tile_done in any other state SHALL be ignored.
REQ-019 ADVANCE: single cycle; increment k; on k wrap increment m; on m wrap increment n; after final (n,m,k) SHALL go to FIN, else ISSUE.
REQ-020 FIN: SHALL set done=1, busy=0, return to IDLE; done SHALL stay 1 until the next accepted start.
REQ-021 Lengths SHALL equal min(TILE, TOTAL-base) per dimension (partial last tile).
REQ-022 acc_clear SHALL be 1 iff tile_k0==0; acc_flush SHALL be 1 iff tile_k0+tile_k_len==K_TOTAL; both valid with tile_valid.
REQ-023 start while not IDLE SHALL be ignored.
REQ-024 Command issue to array completion handshake SHALL add no more than 2 cycles overhead per tile (ADVANCE + ISSUE).
REQ-025 Index arithmetic SHALL be unsigned and wide enough that base+TILE never overflows.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, done=0, busy=0, tile_valid=0, acc_clear=0, acc_flush=0, all indices and lengths 0.
REQ-027 Reset mid-schedule SHALL abandon the schedule; no tile_valid until a new start after rst_n high.

Configuration
REQ-028 With SCHED_PERF_CNT_EN defined, SHALL add outputs perf_cycles (32) counting busy cycles and perf_tiles (32) counting accepted tiles, both cleared by accepted start and reset, frozen at FIN.
REQ-029 Without SCHED_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 Defaults, tile_ready=1, tile_done 3 cycles after acceptance -> exactly 4*196*10=7840 tiles, last tile k0=144 k_len=3 acc_flush=1, then done=1.
REQ-031 M_TOTAL=20,N_TOTAL=16,K_TOTAL=20 -> 4 tiles in order (m0,k0)=(0,0),(0,16),(16,0),(16,16); m_len 16,16,4,4; k_len 16,4,16,4; acc_clear 1,0,1,0.
REQ-032 tile_ready held 0 for 5 cycles in ISSUE -> tile_valid and all fields stable for those 5 cycles, no advance.
REQ-033 Spurious tile_done in IDLE and ISSUE, plus start pulse while busy -> no state change, tile count unchanged.
REQ-034 rst_n low during WAIT of tile 50 -> outputs at reset values immediately; new start replays from tile 0 with acc_clear=1.
REQ-035 SCHED_PERF_CNT_EN defined, REQ-031 run with 2-cycle tile_done latency -> perf_tiles=4, perf_cycles equal to measured busy cycles.
